fpq_scan_ctrl: RTL and testbench

Time-multiplexed 4-digit display scan controller. It sequences digit position, digit-select strobes and the data-mux address from a slow scan tick, which is a 1-cycle pulse from the divider. It inserts an anti-ghosting blank gap between digits, applies optional leading-zero suppression, and steps a display page on a debounced key pulse. It sits between the divider/key-debounce utilities and the 4:1 data mux / segment decoder.

---
 rtl/fpq_pkg.sv | 24 ++
 rtl/fpq_lz_mask.sv | 32 +++
 rtl/fpq_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_fpq_scan_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpq_pkg
// Purpose  : Shared types and constants for the 4-digit display scan slice.
// Revision : 1.0 - initial release
// ============================================================================
package fpq_pkg;

    // Scan FSM: all digits dark (anti-ghost gap) or one digit driven.
    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    localparam int         DIGITS  = 4;
    localparam logic [3:0] DIG_OFF = 4'b1111;

    // Extract BCD digit idx (0 = least significant) from a packed 4-digit word.
    function automatic logic [3:0] get_digit(input logic [15:0] word, input logic [1:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpq_lz_mask.sv
`default_nettype none
// ============================================================================
// Module   : fpq_lz_mask
// Purpose  : Leading-zero mask. Bit k (k=1..3) is set when digits k..3 are all
//            zero; bit 0 is never set so a value of zero still shows one digit.
//            Non-BCD nibbles (A..F) count as non-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpq_lz_mask
    import fpq_pkg::*;
(
    input  logic [15:0] bcd,
    output logic [3:0]  mask
);

    logic zero_run;
    // The least significant digit never takes part in the decision.
    logic unused_lsd;
    assign unused_lsd = ^bcd[3:0];

    // Walk from the most significant digit down, tracking an unbroken run of zeros.
    always_comb begin
        mask     = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (bcd[4*k +: 4] == 4'd0);
            mask[k]  = zero_run;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpq_scan_ctrl
// Purpose  : Time-multiplexed 4-digit display scan controller. Steps digit
//            position on a scan tick with a blank gap between digits, applies
//            optional leading-zero suppression, and steps a display page on a
//            key pulse. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module fpq_scan_ctrl
    import fpq_pkg::*;
#(
    parameter int BLANK_CYC   = 8,
    parameter int PAGES       = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tick,
    input  logic        key_pulse,
    input  logic [15:0] bcd,
    output logic [1:0]  addr,
    output logic [1:0]  page,
    output logic [3:0]  dig_n,
    output logic [3:0]  nib,
    output logic        frame_done
);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [1:0]  addr_nxt, page_nxt;
    logic [3:0]  dig_n_nxt, nib_nxt;
    logic        frame_done_nxt;
    logic [1:0]  addr_inc, page_inc;
    logic [3:0]  lz_mask, sup_mask;

    fpq_lz_mask u_lz_mask (
        .bcd  (bcd),
        .mask (lz_mask)
    );

    assign sup_mask = lz_mask & {4{LZ_SUPPRESS != 0}};

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BLANK;
            cnt        <= '0;
            addr       <= '0;
            page       <= '0;
            dig_n      <= DIG_OFF;
            nib        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr       <= addr_nxt;
            page       <= page_nxt;
            dig_n      <= dig_n_nxt;
            nib        <= nib_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state logic: key restart beats disable, which beats normal scanning.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        addr_nxt       = addr;
        page_nxt       = page;
        dig_n_nxt      = dig_n;
        nib_nxt        = nib;
        frame_done_nxt = 1'b0;
        addr_inc       = addr + 2'd1;
        page_inc       = (page == 2'(PAGES - 1)) ? 2'd0 : page + 2'd1;

        if (key_pulse) begin
            // Page step restarts the scan at digit 0; a same-cycle tick is dropped.
            page_nxt  = page_inc;
            addr_nxt  = 2'd0;
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
            dig_n_nxt = DIG_OFF;
            nib_nxt   = get_digit(bcd, 2'd0);
        end else if (!en) begin
            // Held dark at digit 0 with the gap counter parked, so re-enable
            // always starts with a full blank gap.
            addr_nxt  = 2'd0;
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
            dig_n_nxt = DIG_OFF;
            nib_nxt   = get_digit(bcd, 2'd0);
        end else begin
            case (state)
                S_BLANK: begin
                    if (cnt == 8'(BLANK_CYC - 1)) begin
                        state_nxt = S_DRIVE;
                        dig_n_nxt = sup_mask[addr] ? DIG_OFF : (DIG_OFF ^ (4'b0001 << addr));
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                S_DRIVE: begin
                    if (tick) begin
                        state_nxt      = S_BLANK;
                        cnt_nxt        = '0;
                        dig_n_nxt      = DIG_OFF;
                        addr_nxt       = addr_inc;
                        nib_nxt        = get_digit(bcd, addr_inc);
                        frame_done_nxt = (addr == 2'd3);
                    end
                end
                default: begin
                    state_nxt = S_BLANK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpq_scan_ctrl
// Purpose  : Directed self-checking bench for fpq_scan_ctrl with an expected-
//            digit scoreboard filled on each scan step and drained when the
//            digit goes active.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpq_scan_ctrl;

    localparam int BLANK = 8;

    logic        clk = 1'b0;
    logic        rst, en, tick, key_pulse;
    logic [15:0] bcd;
    logic [1:0]  addr, page;
    logic [3:0]  dig_n, nib;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] m_addr, m_page;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] dig;
        logic [3:0] nib;
        bit         chk_nib;
    } exp_t;

    exp_t sbq[$];

    fpq_scan_ctrl #(
        .BLANK_CYC   (BLANK),
        .PAGES       (4),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick       (tick),
        .key_pulse  (key_pulse),
        .bcd        (bcd),
        .addr       (addr),
        .page       (page),
        .dig_n      (dig_n),
        .nib        (nib),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected active-low strobe for position a, with leading-zero blanking.
    function automatic logic [3:0] exp_dig(input logic [1:0] a, input logic [15:0] b);
        bit sup;
        sup = (a != 2'd0);
        for (int k = 0; k < 4; k++)
            if (k >= int'(a) && b[4*k +: 4] != 4'd0) sup = 1'b0;
        return sup ? 4'b1111 : ~(4'b0001 << a);
    endfunction

    task automatic push_exp(input logic [1:0] a, input logic [3:0] n, input bit c);
        exp_t e;
        e.addr    = a;
        e.dig     = exp_dig(a, bcd);
        e.nib     = n;
        e.chk_nib = c;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        chk("sb_nonempty", 16'(sbq.size() != 0), 16'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("drive_addr", addr, e.addr);
            chk("drive_dig_n", dig_n, e.dig);
            if (e.chk_nib) chk("drive_nib", nib, e.nib);
            chk("drive_page", page, m_page);
        end
    endtask

    // Entered between the restart edge and the next one: checks the gap
    // is still dark on its last cycle, then the digit on the following one.
    task automatic wait_drive();
        repeat (BLANK - 1) @(negedge clk);
        chk("gap_dig_off", dig_n, 4'hF);
        chk("gap_fd_low", frame_done, 1'b0);
        @(negedge clk);
        pop_check();
    endtask

    task automatic do_tick();
        bit fd;
        m_addr = m_addr + 2'd1;
        fd = (m_addr == 2'd0);
        push_exp(m_addr, bcd[4*m_addr +: 4], 1'b1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("tick_addr", addr, m_addr);
        chk("tick_dig_off", dig_n, 4'hF);
        chk("tick_frame_done", frame_done, fd);
        wait_drive();
    endtask

    task automatic do_key(input bit with_tick);
        m_page = m_page + 2'd1;
        m_addr = 2'd0;
        push_exp(2'd0, bcd[3:0], 1'b1);
        key_pulse = 1'b1;
        tick = with_tick;
        @(negedge clk);
        key_pulse = 1'b0;
        tick = 1'b0;
        chk("key_page", page, m_page);
        chk("key_addr", addr, 2'd0);
        chk("key_dig_off", dig_n, 4'hF);
        chk("key_fd_low", frame_done, 1'b0);
        wait_drive();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; tick = 1'b0; key_pulse = 1'b0; bcd = 16'h1234;
        m_addr = 2'd0; m_page = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_addr", addr, 2'd0);
        chk("rst_page", page, 2'd0);
        chk("rst_dig_n", dig_n, 4'hF);
        chk("rst_nib", nib, 4'h0);
        chk("rst_fd", frame_done, 1'b0);
        push_exp(2'd0, 4'h0, 1'b1);
        rst = 1'b0;
        wait_drive();

        // Plain scan of 1234 over one frame.
        repeat (4) do_tick();

        // Leading-zero suppression, all-zero value, and non-BCD nibble.
        bcd = 16'h0005;
        repeat (4) do_tick();
        bcd = 16'h0000;
        repeat (4) do_tick();
        bcd = 16'h0A00;
        repeat (4) do_tick();

        // Second tick three cycles into the blank gap is ignored.
        bcd = 16'h1234;
        m_addr = m_addr + 2'd1;
        push_exp(m_addr, bcd[4*m_addr +: 4], 1'b1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("dbl_addr_first", addr, m_addr);
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("dbl_addr_hold", addr, m_addr);
        chk("dbl_dig_off", dig_n, 4'hF);
        repeat (BLANK - 4) @(negedge clk);
        chk("dbl_gap_dig_off", dig_n, 4'hF);
        @(negedge clk);
        pop_check();

        // Page stepping; key and tick together at addr=2, page=3.
        do_key(1'b0);
        do_key(1'b0);
        do_key(1'b0);
        while (m_addr != 2'd2) do_tick();
        chk("pre_key_page", page, 2'd3);
        do_key(1'b1);

        // Disable mid-frame with ticks and a key present.
        do_tick();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick = (i % 5 == 2);
            key_pulse = (i == 10);
            if (i == 10) m_page = m_page + 2'd1;
            @(negedge clk);
            tick = 1'b0;
            key_pulse = 1'b0;
            chk("en0_dig_off", dig_n, 4'hF);
            chk("en0_addr", addr, 2'd0);
            chk("en0_fd", frame_done, 1'b0);
        end
        chk("en0_page", page, m_page);
        en = 1'b1;
        m_addr = 2'd0;
        push_exp(2'd0, bcd[3:0], 1'b0);
        wait_drive();

        // Reset while driving addr=2 on page 1.
        do_tick();
        do_tick();
        chk("pre_rst_page", page, 2'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr", addr, 2'd0);
        chk("mid_rst_page", page, 2'd0);
        chk("mid_rst_dig_n", dig_n, 4'hF);
        chk("mid_rst_nib", nib, 4'h0);
        chk("mid_rst_fd", frame_done, 1'b0);
        m_addr = 2'd0;
        m_page = 2'd0;
        push_exp(2'd0, 4'h0, 1'b1);
        rst = 1'b0;
        wait_drive();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
